midi_msg_parser: RTL and testbench
==================================

MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 SHALL have parameter INPUT_CLOCK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default INPUT_CLOCK_FREQ/100 (10 ms), the maximum allowed gap between bytes of one message.
REQ-003 SHALL have parameter ZERO_VEL_IS_OFF, default 1; when set, a note-on with velocity 0 is reported as note-off.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-006 byte_valid_in  input  1  single-cycle strobe from the UART receiver: byte_in is valid.
REQ-007 byte_in  input  8  received MIDI byte.
REQ-008 msg_valid_out  output  1  assembled channel message held on the msg_* outputs.
REQ-009 msg_ready_in  input  1  consumer accepts the message.
REQ-010 msg_status_out  output  8  status byte (type nibble + channel).
REQ-011 msg_data1_out  output  7  first data byte (note/controller/program).
REQ-012 msg_data2_out  output  7  second data byte; 0 for one-data-byte types.
REQ-013 rt_valid_out  output  1  one-cycle pulse: real-time byte on rt_byte_out.
REQ-014 rt_byte_out  output  8  last real-time byte (0xF8-0xFF).
REQ-015 overrun_out  output  1  one-cycle pulse: a completed message was dropped.

Function
REQ-016 SHALL use FSM states NO_STATUS, WAIT_D1, WAIT_D2, SYSEX.
REQ-017 Status 0x8n, 0x9n, 0xAn, 0xBn, 0xEn SHALL latch the running status, expect 2 data bytes, and go to WAIT_D1.
REQ-018 Status 0xCn, 0xDn SHALL latch the running status, expect 1 data byte, and go to WAIT_D1.
REQ-019 Data byte (bit7=0) in WAIT_D1 SHALL latch data1; for a 1-byte type it completes the message and the FSM stays in WAIT_D1; otherwise it goes to WAIT_D2.
REQ-020 Data byte in WAIT_D2 SHALL complete the message and return to WAIT_D1 (running status).
REQ-021 Data bytes in NO_STATUS or SYSEX SHALL be discarded.
REQ-022 0xF0 SHALL clear the running status and enter SYSEX; 0xF1-0xF7 SHALL clear the running status and enter NO_STATUS.
REQ-023 Any channel status byte received in any state, including mid-message, SHALL abort the partial message and restart per REQ-017/018.
REQ-024 Bytes 0xF8-0xFF SHALL drive rt_byte_out and pulse rt_valid_out on the next cycle, and SHALL NOT change FSM state, partial data or the timeout counter.
REQ-025 Timeout counter SHALL clear on every non-real-time byte, count up while in WAIT_D2, or in WAIT_D1 with data1 pending, and saturate; on reaching TIMEOUT_CYCLES-1 it SHALL discard the partial message and return to WAIT_D1, keeping the running status.
REQ-026 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-027 A completed message SHALL appear on msg_* with msg_valid_out=1 on the cycle after the completing byte_valid_in (latency 1).
REQ-028 msg_* outputs SHALL be stable while msg_valid_out=1 and msg_ready_in=0; transfer occurs when both are 1.
REQ-029 If a message completes while msg_valid_out=1 and msg_ready_in=0, the new message SHALL be dropped, the held one kept, and overrun_out pulsed.
REQ-030 If a message completes in the same cycle as a transfer, the new message SHALL load and msg_valid_out SHALL remain 1.
REQ-031 With ZERO_VEL_IS_OFF=1, 0x9n with data2=0 SHALL be output as 0x8n with data2=0.
REQ-032 A byte_valid_in arriving in the cycle a timeout fires SHALL be processed, and the timeout SHALL be ignored.

Reset
REQ-033 rst_n_in low SHALL asynchronously force NO_STATUS, clear the running status, partial data and counter, and set every output to 0.
REQ-034 Reset mid-message SHALL discard all partial and held messages; after release, data bytes are discarded until a status byte arrives.

Structure
REQ-035 Package midi_pkg SHALL hold the FSM state enum, status-nibble constants (NOTE_OFF=8 ... PITCH_BEND=E), and the SYSEX_START/SYSEX_END/RT_MIN byte constants.
REQ-036 SHALL be a single module with the timeout counter inline; no sub-module.

Verification
REQ-037 Bytes 0x93,0x3C,0x64 with ready=1 -> one msg_valid_out: status 0x93, d1 0x3C, d2 0x64, one cycle after the third strobe.
REQ-038 0x90,0x3C,0x64,0x40,0x00 (ZERO_VEL_IS_OFF=1) -> two messages: {0x90,0x3C,0x64} then {0x80,0x40,0x00}.
REQ-039 0xC2,0x05,0x07 -> messages {0xC2,0x05,0} and {0xC2,0x07,0}.
REQ-040 0x90,0x3C,0xF8,0x64 -> rt pulse with 0xF8, then message {0x90,0x3C,0x64}.
REQ-041 ready=0, two complete note-ons -> first held unchanged, overrun_out pulses once on the second completion.
REQ-042 0x90,0x3C, no byte for TIMEOUT_CYCLES, then 0x40,0x7F -> no message from 0x3C; message {0x90,0x40,0x7F}. Repeat with rst_n_in pulsed after 0x3C -> then 0x40,0x7F yields no message.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI parser types: FSM state encoding, channel-voice status nibbles
// and the system byte constants used to classify incoming bytes.
package midi_pkg;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SYSEX     = 2'd3
  } midi_state_e;

  localparam logic [3:0] NOTE_OFF    = 4'h8;
  localparam logic [3:0] NOTE_ON     = 4'h9;
  localparam logic [3:0] POLY_AT     = 4'hA;
  localparam logic [3:0] CTRL_CHANGE = 4'hB;
  localparam logic [3:0] PROG_CHANGE = 4'hC;
  localparam logic [3:0] CHAN_AT     = 4'hD;
  localparam logic [3:0] PITCH_BEND  = 4'hE;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic is_one_data(input logic [3:0] nibble);
    return (nibble == PROG_CHANGE) || (nibble == CHAN_AT);
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: assembles channel-voice messages with running status,
// forwards real-time bytes, and times out stalled partial messages.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int TIMEOUT_CYCLES   = INPUT_CLOCK_FREQ / 100,
  parameter bit ZERO_VEL_IS_OFF  = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       byte_valid_in,
  input  logic [7:0] byte_in,
  output logic       msg_valid_out,
  input  logic       msg_ready_in,
  output logic [7:0] msg_status_out,
  output logic [6:0] msg_data1_out,
  output logic [6:0] msg_data2_out,
  output logic       rt_valid_out,
  output logic [7:0] rt_byte_out,
  output logic       overrun_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  midi_state_e      state_q, state_d;
  logic [7:0]       status_q, status_d;
  logic             one_byte_q, one_byte_d;
  logic             pending_q, pending_d;
  logic [6:0]       d1_q, d1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             msg_valid_q, msg_valid_d;
  logic [7:0]       msg_status_q, msg_status_d;
  logic [6:0]       msg_data1_q, msg_data1_d;
  logic [6:0]       msg_data2_q, msg_data2_d;
  logic             rt_valid_q, rt_valid_d;
  logic [7:0]       rt_byte_q, rt_byte_d;
  logic             overrun_q, overrun_d;

  logic       done;
  logic [6:0] done_d1;
  logic [6:0] done_d2;
  logic [7:0] done_status;
  logic       is_rt;
  logic       counting;

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    one_byte_d   = one_byte_q;
    pending_d    = pending_q;
    d1_d         = d1_q;
    cnt_d        = cnt_q;
    msg_valid_d  = msg_valid_q;
    msg_status_d = msg_status_q;
    msg_data1_d  = msg_data1_q;
    msg_data2_d  = msg_data2_q;
    rt_valid_d   = 1'b0;
    rt_byte_d    = rt_byte_q;
    overrun_d    = 1'b0;
    done         = 1'b0;
    done_d1      = d1_q;
    done_d2      = 7'd0;
    done_status  = status_q;
    is_rt        = (byte_in >= RT_MIN);
    counting     = (state_q == WAIT_D2) || ((state_q == WAIT_D1) && pending_q);

    if (byte_valid_in && is_rt) begin
      rt_valid_d = 1'b1;
      rt_byte_d  = byte_in;
    end

    // Real-time bytes fall through to the timeout branch so they never reset it.
    if (byte_valid_in && !is_rt) begin
      cnt_d = '0;
      if (byte_in[7]) begin
        if (byte_in[7:4] == 4'hF) begin
          status_d  = 8'h00;
          pending_d = 1'b0;
          state_d   = (byte_in == SYSEX_START) ? SYSEX : NO_STATUS;
        end else begin
          status_d   = byte_in;
          one_byte_d = is_one_data(byte_in[7:4]);
          pending_d  = 1'b1;
          state_d    = WAIT_D1;
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d      = byte_in[6:0];
            done_d1   = byte_in[6:0];
            pending_d = 1'b0;
            if (one_byte_q) begin
              done = 1'b1;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            done    = 1'b1;
            done_d2 = byte_in[6:0];
            state_d = WAIT_D1;
          end
          default: ;
        endcase
      end
    end else if (counting) begin
      if (cnt_q == CNT_FIRE) begin
        state_d   = WAIT_D1;
        pending_d = 1'b0;
        cnt_d     = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (ZERO_VEL_IS_OFF && (status_q[7:4] == NOTE_ON) && (done_d2 == 7'd0)) begin
      done_status = {NOTE_OFF, status_q[3:0]};
    end

    // A completing message loads if the output slot is empty or draining this cycle.
    if (done) begin
      if (!msg_valid_q || msg_ready_in) begin
        msg_valid_d  = 1'b1;
        msg_status_d = done_status;
        msg_data1_d  = done_d1;
        msg_data2_d  = done_d2;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (msg_valid_q && msg_ready_in) begin
      msg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= NO_STATUS;
      status_q     <= 8'h00;
      one_byte_q   <= 1'b0;
      pending_q    <= 1'b0;
      d1_q         <= 7'd0;
      cnt_q        <= '0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= 8'h00;
      msg_data1_q  <= 7'd0;
      msg_data2_q  <= 7'd0;
      rt_valid_q   <= 1'b0;
      rt_byte_q    <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      one_byte_q   <= one_byte_d;
      pending_q    <= pending_d;
      d1_q         <= d1_d;
      cnt_q        <= cnt_d;
      msg_valid_q  <= msg_valid_d;
      msg_status_q <= msg_status_d;
      msg_data1_q  <= msg_data1_d;
      msg_data2_q  <= msg_data2_d;
      rt_valid_q   <= rt_valid_d;
      rt_byte_q    <= rt_byte_d;
      overrun_q    <= overrun_d;
    end
  end

  assign msg_valid_out  = msg_valid_q;
  assign msg_status_out = msg_status_q;
  assign msg_data1_out  = msg_data1_q;
  assign msg_data2_out  = msg_data2_q;
  assign rt_valid_out   = rt_valid_q;
  assign rt_byte_out    = rt_byte_q;
  assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Randomized and directed bench for midi_msg_parser, checked cycle by cycle
// against a message-level reference model of the MIDI byte stream.
module tb_midi_msg_parser;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       byteValid = 1'b0;
  logic [7:0] byteIn = 8'h00;
  logic       msgReady = 1'b0;
  logic       msgValid;
  logic [7:0] msgStatus;
  logic [6:0] msgData1;
  logic [6:0] msgData2;
  logic       rtValid;
  logic [7:0] rtByte;
  logic       overrun;

  always #5 clk = ~clk;

  midi_msg_parser #(
    .INPUT_CLOCK_FREQ(100_000_000),
    .TIMEOUT_CYCLES  (TIMEOUT),
    .ZERO_VEL_IS_OFF (1'b1)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rstN),
    .byte_valid_in (byteValid),
    .byte_in       (byteIn),
    .msg_valid_out (msgValid),
    .msg_ready_in  (msgReady),
    .msg_status_out(msgStatus),
    .msg_data1_out (msgData1),
    .msg_data2_out (msgData2),
    .rt_valid_out  (rtValid),
    .rt_byte_out   (rtByte),
    .overrun_out   (overrun)
  );

  int checks = 0;
  int errors = 0;
  int ovrSeen = 0;

  // Reference model: running status plus the data bytes collected so far.
  int         runStatus = -1;
  int         dataQ[$];
  int         cycleNum = 0;
  int         lastByteCycle = 0;
  bit         expValid = 1'b0;
  logic [7:0] expStatus = 8'h00;
  logic [6:0] expD1 = 7'd0;
  logic [6:0] expD2 = 7'd0;
  bit         expRtValid = 1'b0;
  logic [7:0] expRtByte = 8'h00;
  bit         expOverrun = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycleNum);
    end
  endtask

  task automatic modelByte(input logic [7:0] b, output bit done, output logic [7:0] st,
                           output logic [6:0] d1, output logic [6:0] d2);
    int need;
    int hi;
    done = 1'b0;
    st   = 8'h00;
    d1   = 7'd0;
    d2   = 7'd0;
    if (dataQ.size() > 0 && (cycleNum - lastByteCycle) > TIMEOUT) dataQ.delete();
    lastByteCycle = cycleNum;
    if (b[7]) begin
      runStatus = (b[7:4] == 4'hF) ? -1 : int'(b);
      dataQ.delete();
    end else if (runStatus >= 0) begin
      dataQ.push_back(int'(b));
      hi   = runStatus >> 4;
      need = (hi == 12 || hi == 13) ? 1 : 2;
      if (dataQ.size() == need) begin
        done = 1'b1;
        st   = 8'(runStatus);
        d1   = 7'(dataQ[0]);
        if (need == 2) d2 = 7'(dataQ[1]);
        if (hi == 9 && d2 == 7'd0) st = 8'(runStatus - 16);
        dataQ.delete();
      end
    end
  endtask

  task automatic applyStimulus(input bit bv, input logic [7:0] b, input bit rdy);
    bit         done;
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    done       = 1'b0;
    st         = 8'h00;
    d1         = 7'd0;
    d2         = 7'd0;
    byteValid  = bv;
    byteIn     = b;
    msgReady   = rdy;
    expRtValid = 1'b0;
    expOverrun = 1'b0;
    if (bv) begin
      if (b >= 8'hF8) begin
        expRtValid = 1'b1;
        expRtByte  = b;
      end else begin
        modelByte(b, done, st, d1, d2);
      end
    end
    if (done) begin
      if (!expValid || rdy) begin
        expValid  = 1'b1;
        expStatus = st;
        expD1     = d1;
        expD2     = d2;
      end else begin
        expOverrun = 1'b1;
      end
    end else if (expValid && rdy) begin
      expValid = 1'b0;
    end
    @(posedge clk);
    #1;
    cycleNum++;
    byteValid = 1'b0;
    if (overrun === 1'b1) ovrSeen++;
    checkOutput("msg_valid", 32'(msgValid), 32'(expValid));
    if (expValid) begin
      checkOutput("msg_status", 32'(msgStatus), 32'(expStatus));
      checkOutput("msg_data1", 32'(msgData1), 32'(expD1));
      checkOutput("msg_data2", 32'(msgData2), 32'(expD2));
    end
    checkOutput("rt_valid", 32'(rtValid), 32'(expRtValid));
    if (expRtValid) checkOutput("rt_byte", 32'(rtByte), 32'(expRtByte));
    checkOutput("overrun", 32'(overrun), 32'(expOverrun));
  endtask

  task automatic sendByte(input logic [7:0] b, input bit rdy);
    applyStimulus(1'b1, b, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, rdy);
  endtask

  task automatic doReset();
    rstN      = 1'b0;
    byteValid = 1'b0;
    msgReady  = 1'b0;
    #1;
    checkOutput("rst_msg_valid", 32'(msgValid), 32'd0);
    checkOutput("rst_msg_status", 32'(msgStatus), 32'd0);
    checkOutput("rst_msg_data1", 32'(msgData1), 32'd0);
    checkOutput("rst_msg_data2", 32'(msgData2), 32'd0);
    checkOutput("rst_rt_valid", 32'(rtValid), 32'd0);
    checkOutput("rst_rt_byte", 32'(rtByte), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    runStatus  = -1;
    dataQ.delete();
    expValid   = 1'b0;
    expRtValid = 1'b0;
    expOverrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycleNum += 2;
    lastByteCycle = cycleNum;
    rstN = 1'b1;
  endtask

  initial begin
    int ovrBefore;
    int r;
    logic [7:0] b;

    @(posedge clk);
    #1;
    doReset();

    // Single note-on with ready held high.
    sendByte(8'h93, 1'b1);
    sendByte(8'h3C, 1'b1);
    sendByte(8'h64, 1'b1);
    checkOutput("note_on_valid", 32'(msgValid), 32'd1);
    checkOutput("note_on_status", 32'(msgStatus), 32'h93);
    checkOutput("note_on_d1", 32'(msgData1), 32'h3C);
    checkOutput("note_on_d2", 32'(msgData2), 32'h64);
    idle(2, 1'b1);

    // Running status with a zero-velocity note-on turned into note-off.
    sendByte(8'h90, 1'b1);
    sendByte(8'h3C, 1'b1);
    sendByte(8'h64, 1'b1);
    sendByte(8'h40, 1'b1);
    sendByte(8'h00, 1'b1);
    checkOutput("zero_vel_status", 32'(msgStatus), 32'h80);
    checkOutput("zero_vel_d1", 32'(msgData1), 32'h40);
    idle(2, 1'b1);

    // One-data-byte program change under running status.
    sendByte(8'hC2, 1'b1);
    sendByte(8'h05, 1'b1);
    sendByte(8'h07, 1'b1);
    checkOutput("prog_status", 32'(msgStatus), 32'hC2);
    checkOutput("prog_d1", 32'(msgData1), 32'h07);
    checkOutput("prog_d2", 32'(msgData2), 32'h00);
    idle(2, 1'b1);

    // Real-time byte interleaved mid-message.
    sendByte(8'h90, 1'b1);
    sendByte(8'h3C, 1'b1);
    sendByte(8'hF8, 1'b1);
    checkOutput("rt_pulse", 32'(rtValid), 32'd1);
    checkOutput("rt_value", 32'(rtByte), 32'hF8);
    sendByte(8'h64, 1'b1);
    checkOutput("rt_msg_d2", 32'(msgData2), 32'h64);
    idle(2, 1'b1);

    // Back-pressure: second completion is dropped with one overrun pulse.
    ovrBefore = ovrSeen;
    sendByte(8'h90, 1'b0);
    sendByte(8'h3C, 1'b0);
    sendByte(8'h64, 1'b0);
    sendByte(8'h91, 1'b0);
    sendByte(8'h40, 1'b0);
    sendByte(8'h50, 1'b0);
    idle(3, 1'b0);
    checkOutput("held_status", 32'(msgStatus), 32'h90);
    checkOutput("held_d1", 32'(msgData1), 32'h3C);
    checkOutput("overrun_count", 32'(ovrSeen - ovrBefore), 32'd1);
    idle(2, 1'b1);

    // Timeout: gap longer than the limit discards the pending first data byte.
    sendByte(8'h90, 1'b1);
    sendByte(8'h3C, 1'b1);
    idle(TIMEOUT + 2, 1'b1);
    sendByte(8'h40, 1'b1);
    checkOutput("timeout_no_msg", 32'(msgValid), 32'd0);
    sendByte(8'h7F, 1'b1);
    checkOutput("timeout_d1", 32'(msgData1), 32'h40);
    checkOutput("timeout_d2", 32'(msgData2), 32'h7F);
    idle(2, 1'b1);

    // A byte arriving exactly as the timeout would fire still completes.
    sendByte(8'h90, 1'b1);
    sendByte(8'h3C, 1'b1);
    idle(TIMEOUT - 1, 1'b1);
    sendByte(8'h40, 1'b1);
    checkOutput("edge_gap_d2", 32'(msgData2), 32'h40);
    idle(2, 1'b1);

    // Reset mid-message forgets the running status.
    sendByte(8'h90, 1'b1);
    sendByte(8'h3C, 1'b1);
    doReset();
    sendByte(8'h40, 1'b1);
    sendByte(8'h7F, 1'b1);
    checkOutput("post_reset_no_msg", 32'(msgValid), 32'd0);

    // Randomized traffic across all byte classes, gaps and back-pressure.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        idle(TIMEOUT - 2 + int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7);
      end else if (r < 45) begin
        applyStimulus(1'b0, 8'h00, $urandom_range(0, 9) < 7);
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 45)      b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(0, 127));
        else if (r < 75) b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 15))};
        else if (r < 82) b = 8'($urandom_range(8'hF0, 8'hF7));
        else             b = 8'($urandom_range(8'hF8, 8'hFF));
        sendByte(b, $urandom_range(0, 9) < 7);
      end
    end
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
